mem_access: RTL and testbench
=============================

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter TIMEOUT, default 255: max cycles waiting for dbus_ack before an access fault.
REQ-002 clk  in  1  single clock, rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 in_valid  in  1  execute-stage result valid.
REQ-005 pc  in  64; rd  in  5; result  in  64 (ALU result or effective address); data2  in  64 (store data).
REQ-006 load_op  in  1; store_op  in  1; size  in  2 (0=B,1=H,2=W,3=D); load_unsigned  in  1.
REQ-007 cause_in  in  5; tval_in  in  64: upstream trap; nonzero cause_in means trap pending.
REQ-008 stall  out  1  hold the execute stage.
REQ-009 dbus_req  out  1; dbus_we  out  1; dbus_addr  out  64; dbus_wdata  out  64; dbus_wstrb  out  8.
REQ-010 dbus_ack  in  1; dbus_err  in  1; dbus_rdata  in  64 (aligned 8-byte word).
REQ-011 wb_valid  out  1; wb_pc  out  64; wb_rd  out  5; wb_data  out  64; wb_cause  out  5; wb_tval  out  64.

Function
REQ-012 States SHALL be IDLE and BUSY only.
REQ-013 IDLE, in_valid, no mem op or cause_in!=0: register pc/rd/result/cause_in/tval_in to wb_* next edge, wb_valid=1, stall=0, no bus request.
REQ-014 IDLE, in_valid, mem op, cause_in==0, address misaligned for size: no bus request; next edge wb_valid=1, wb_cause=4 (load) or 6 (store), wb_tval=result, wb_rd=0.
REQ-015 IDLE, in_valid, aligned mem op: dbus_req=1 combinationally, stall=1, go BUSY next edge; neither load_op nor store_op means no mem op; both set is illegal, treat as store.
REQ-016 dbus_addr=result; dbus_we=store_op; dbus_wstrb = {0x01,0x03,0x0F,0xFF}[size] << result[2:0]; dbus_wdata = data2 << 8*result[2:0].
REQ-017 BUSY: dbus_req held at 1 with stable addr/we/wdata/wstrb until the ack/err/timeout cycle.
REQ-018 stall = BUSY & ~dbus_ack & ~dbus_err & ~timeout, OR the IDLE issue condition of REQ-015.
REQ-019 BUSY with dbus_ack: return IDLE; next edge wb_valid=1, wb_cause=0; loads: wb_data = byte lane result[2:0] of dbus_rdata, size-extended, zero-extended if load_unsigned else sign-extended; stores: wb_data=0, wb_rd=0.
REQ-020 BUSY with dbus_err (no ack): return IDLE; wb_cause=5 (load) or 7 (store), wb_tval=result, wb_rd=0.
REQ-021 Wait counter clears on entering BUSY and increments each BUSY cycle; count==TIMEOUT-1 without ack/err is timeout, handled as dbus_err.
REQ-022 Same-cycle priority: dbus_ack over dbus_err over timeout.
REQ-023 wb_valid SHALL be a one-cycle pulse per accepted instruction; zero when nothing completes.
REQ-024 Upstream SHALL hold in_valid and all inputs stable while stall=1; the block does not re-sample them.
REQ-025 dbus_ack/dbus_err in IDLE SHALL be ignored.

Reset
REQ-026 rst at an edge: state=IDLE, counter=0, wb_valid=0, wb_* data=0; dbus_req and stall then 0 unless a new REQ-015 issue is presented.
REQ-027 rst mid-BUSY SHALL abandon the transaction without wb_valid; a late dbus_ack SHALL be ignored per REQ-025.

Structure
REQ-028 Shared package holds state enum, size encodings, cause codes (4,5,6,7), strobe table.
REQ-029 One sub-module, load_align (rdata, offset, size, unsigned -> extended data), combinational.

Verification
REQ-030 LD W signed, result=0x1004, dbus_rdata=0x8000_0001_0000_0000, ack after 3 cycles -> stall 3 cycles, wb_data=0xFFFF_FFFF_8000_0001, wb_cause=0.
REQ-031 SB, result=0x2003, data2=0xAB -> dbus_wstrb=0x08, dbus_wdata=0xAB00_0000, dbus_we=1; ack -> wb_valid, wb_rd=0.
REQ-032 LH, result=0x1001 -> no dbus_req, wb_cause=4, wb_tval=0x1001.
REQ-033 TIMEOUT=4, LD D no ack -> stall 4 cycles, wb_cause=5, wb_tval=address; ack+err same cycle -> completes normally.
REQ-034 rst in second BUSY cycle, ack next cycle -> no wb_valid, dbus_req=0, stall=0.
REQ-035 Back-to-back ALU ops, cause_in=2 on second -> two wb_valid pulses, no stall, second wb_cause=2.

Source files
------------

// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared types and constants for the memory-access stage.
`default_nettype none
package mem_access_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  localparam logic [4:0] CAUSE_LD_MISALIGN = 5'd4;
  localparam logic [4:0] CAUSE_LD_FAULT    = 5'd5;
  localparam logic [4:0] CAUSE_ST_MISALIGN = 5'd6;
  localparam logic [4:0] CAUSE_ST_FAULT    = 5'd7;

  // Byte-enable pattern per size, byte-lane 0 aligned: {D, W, H, B}.
  localparam logic [31:0] STRB_TABLE = 32'hFF0F_0301;

  function automatic logic [7:0] size_strb(input logic [1:0] size);
    return STRB_TABLE[{size, 3'b000} +: 8];
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] off);
    logic r;
    case (size)
      SZ_H:    r = off[0];
      SZ_W:    r = |off[1:0];
      SZ_D:    r = |off;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_if.sv
// mem_access_if: data-bus request/response bundle between the stage and memory.
`default_nettype none
interface mem_access_if;
  logic        dbus_req;
  logic        dbus_we;
  logic [63:0] dbus_addr;
  logic [63:0] dbus_wdata;
  logic [7:0]  dbus_wstrb;
  logic        dbus_ack;
  logic        dbus_err;
  logic [63:0] dbus_rdata;

  modport master (
    output dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_wstrb,
    input  dbus_ack, dbus_err, dbus_rdata
  );

  modport slave (
    input  dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_wstrb,
    output dbus_ack, dbus_err, dbus_rdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_access_load_align.sv
// mem_access_load_align: extracts the addressed lane of a read word and extends it.
`default_nettype none
module mem_access_load_align
  import mem_access_pkg::*;
(
  input  wire logic [63:0] i_rdata,
  input  wire logic [2:0]  i_offset,
  input  wire logic [1:0]  i_size,
  input  wire logic        i_unsigned,
  output logic      [63:0] o_data
);

  logic [63:0] w_shifted;

  assign w_shifted = i_rdata >> {i_offset, 3'b000};

  always_comb begin
    o_data = w_shifted;
    case (i_size)
      SZ_B: o_data = i_unsigned ? {56'd0, w_shifted[7:0]}
                                : {{56{w_shifted[7]}}, w_shifted[7:0]};
      SZ_H: o_data = i_unsigned ? {48'd0, w_shifted[15:0]}
                                : {{48{w_shifted[15]}}, w_shifted[15:0]};
      SZ_W: o_data = i_unsigned ? {32'd0, w_shifted[31:0]}
                                : {{32{w_shifted[31]}}, w_shifted[31:0]};
      default: o_data = w_shifted;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access.sv
// mem_access: memory stage; issues one data-bus access per load/store and retires results.
`default_nettype none
module mem_access
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        in_valid,
  input  wire logic [63:0] pc,
  input  wire logic [4:0]  rd,
  input  wire logic [63:0] result,
  input  wire logic [63:0] data2,
  input  wire logic        load_op,
  input  wire logic        store_op,
  input  wire logic [1:0]  size,
  input  wire logic        load_unsigned,
  input  wire logic [4:0]  cause_in,
  input  wire logic [63:0] tval_in,
  output logic             stall,
  mem_access_if.master     dbus,
  output logic             wb_valid,
  output logic      [63:0] wb_pc,
  output logic      [4:0]  wb_rd,
  output logic      [63:0] wb_data,
  output logic      [4:0]  wb_cause,
  output logic      [63:0] wb_tval
);

  localparam int               CW     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0]    C_LAST = CW'(TIMEOUT - 1);

  state_t        r_state;
  state_t        w_next_state;
  logic [CW-1:0] r_count;

  logic        w_mem_op, w_is_store, w_trap, w_misal, w_idle_take, w_issue;
  logic        w_busy, w_timeout, w_done_ack, w_done_err;
  logic [63:0] w_load_data;

  logic        r_wb_valid;
  logic [63:0] r_wb_pc, r_wb_data, r_wb_tval;
  logic [4:0]  r_wb_rd, r_wb_cause;

  // Both op bits set is treated as a store.
  assign w_mem_op    = load_op | store_op;
  assign w_is_store  = store_op;
  assign w_trap      = |cause_in;
  assign w_misal     = is_misaligned(size, result[2:0]);
  assign w_idle_take = (r_state == ST_IDLE) && in_valid;
  assign w_issue     = w_idle_take && w_mem_op && !w_trap && !w_misal;
  assign w_busy      = (r_state == ST_BUSY);
  assign w_timeout   = w_busy && (r_count == C_LAST);
  assign w_done_ack  = w_busy && dbus.dbus_ack;
  assign w_done_err  = w_busy && !dbus.dbus_ack && (dbus.dbus_err || w_timeout);

  // Upstream holds its inputs while stalled, so the bus fields follow them directly.
  assign dbus.dbus_addr  = result;
  assign dbus.dbus_we    = w_is_store;
  assign dbus.dbus_wstrb = size_strb(size) << result[2:0];
  assign dbus.dbus_wdata = data2 << {result[2:0], 3'b000};

  mem_access_load_align u_load_align (
    .i_rdata    (dbus.dbus_rdata),
    .i_offset   (result[2:0]),
    .i_size     (size),
    .i_unsigned (load_unsigned),
    .o_data     (w_load_data)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_issue) w_next_state = ST_BUSY;
      ST_BUSY: if (w_done_ack || w_done_err) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    dbus.dbus_req = 1'b0;
    stall         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        dbus.dbus_req = w_issue;
        stall         = w_issue;
      end
      ST_BUSY: begin
        dbus.dbus_req = 1'b1;
        stall         = !dbus.dbus_ack && !dbus.dbus_err && !w_timeout;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || w_issue) r_count <= '0;
    else if (w_busy)    r_count <= r_count + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb_valid <= 1'b0;
      r_wb_pc    <= '0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
      r_wb_cause <= '0;
      r_wb_tval  <= '0;
    end else begin
      r_wb_valid <= 1'b0;
      if (w_idle_take && !w_issue) begin
        r_wb_valid <= 1'b1;
        r_wb_pc    <= pc;
        if (!w_mem_op || w_trap) begin
          r_wb_rd    <= rd;
          r_wb_data  <= result;
          r_wb_cause <= cause_in;
          r_wb_tval  <= tval_in;
        end else begin
          r_wb_rd    <= '0;
          r_wb_data  <= '0;
          r_wb_cause <= w_is_store ? CAUSE_ST_MISALIGN : CAUSE_LD_MISALIGN;
          r_wb_tval  <= result;
        end
      end else if (w_done_ack) begin
        r_wb_valid <= 1'b1;
        r_wb_pc    <= pc;
        r_wb_rd    <= w_is_store ? 5'd0 : rd;
        r_wb_data  <= w_is_store ? 64'd0 : w_load_data;
        r_wb_cause <= '0;
        r_wb_tval  <= '0;
      end else if (w_done_err) begin
        r_wb_valid <= 1'b1;
        r_wb_pc    <= pc;
        r_wb_rd    <= '0;
        r_wb_data  <= '0;
        r_wb_cause <= w_is_store ? CAUSE_ST_FAULT : CAUSE_LD_FAULT;
        r_wb_tval  <= result;
      end
    end
  end

  assign wb_valid = r_wb_valid;
  assign wb_pc    = r_wb_pc;
  assign wb_rd    = r_wb_rd;
  assign wb_data  = r_wb_data;
  assign wb_cause = r_wb_cause;
  assign wb_tval  = r_wb_tval;

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
// tb_mem_access: directed self-checking bench for mem_access (TIMEOUT=4).
`default_nettype none
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, load_op, store_op, load_unsigned;
  logic [63:0] pc, result, data2, tval_in;
  logic [4:0]  rd, cause_in;
  logic [1:0]  size;
  logic        stall, wb_valid;
  logic [63:0] wb_pc, wb_data, wb_tval;
  logic [4:0]  wb_rd, wb_cause;

  int checks   = 0;
  int failures = 0;

  mem_access_if bus ();

  mem_access #(.TIMEOUT(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .pc            (pc),
    .rd            (rd),
    .result        (result),
    .data2         (data2),
    .load_op       (load_op),
    .store_op      (store_op),
    .size          (size),
    .load_unsigned (load_unsigned),
    .cause_in      (cause_in),
    .tval_in       (tval_in),
    .stall         (stall),
    .dbus          (bus.master),
    .wb_valid      (wb_valid),
    .wb_pc         (wb_pc),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .wb_cause      (wb_cause),
    .wb_tval       (wb_tval)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    in_valid = 0; load_op = 0; store_op = 0; size = 0; load_unsigned = 0;
    cause_in = 0; tval_in = 0; pc = 0; rd = 0; result = 0; data2 = 0;
    bus.dbus_ack = 0; bus.dbus_err = 0; bus.dbus_rdata = 0;
  endtask

  task automatic present(input logic ld, input logic st, input logic [1:0] sz,
                         input logic uns, input logic [63:0] a, input logic [63:0] d,
                         input logic [4:0] r, input logic [63:0] p);
    in_valid = 1; load_op = ld; store_op = st; size = sz; load_unsigned = uns;
    result = a; data2 = d; rd = r; pc = p; cause_in = 0; tval_in = 0;
  endtask

  // Drives the bus response on cycle ack_cyc after issue; stops on the first non-stall cycle.
  task automatic wait_done(input int ack_cyc, input logic ack_v, input logic err_v,
                           input logic [63:0] rdata, output int stalls, output bit done);
    stalls = 0;
    done   = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (stall) stalls++;
      else done = 1;
      if (!done) begin
        step();
        if (i + 1 == ack_cyc) begin
          bus.dbus_ack = ack_v; bus.dbus_err = err_v; bus.dbus_rdata = rdata;
        end
        #1;
      end
    end
  endtask

  task automatic test_reset();
    clear_in();
    rst = 1;
    step();
    step();
    rst = 0;
    #1;
    checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL reset_wb_valid got=%b exp=0", wb_valid); end
    checks++; if (wb_data !== 64'd0) begin failures++; $display("FAIL reset_wb_data got=%h exp=0", wb_data); end
    checks++; if (wb_cause !== 5'd0) begin failures++; $display("FAIL reset_wb_cause got=%h exp=0", wb_cause); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
    checks++; if (bus.dbus_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", bus.dbus_req); end
  endtask

  task automatic test_ld_word();
    int st; bit dn;
    present(1, 0, 2'd2, 0, 64'h1004, 64'h0, 5'd5, 64'h100);
    #1;
    checks++; if (bus.dbus_req !== 1'b1) begin failures++; $display("FAIL ldw_req got=%b exp=1", bus.dbus_req); end
    checks++; if (bus.dbus_we !== 1'b0) begin failures++; $display("FAIL ldw_we got=%b exp=0", bus.dbus_we); end
    checks++; if (bus.dbus_wstrb !== 8'hF0) begin failures++; $display("FAIL ldw_wstrb got=%h exp=f0", bus.dbus_wstrb); end
    wait_done(3, 1'b1, 1'b0, 64'h8000_0001_0000_0000, st, dn);
    checks++; if (dn !== 1'b1) begin failures++; $display("FAIL ldw_done got=%b exp=1", dn); end
    checks++; if (st !== 3) begin failures++; $display("FAIL ldw_stall_cycles got=%0d exp=3", st); end
    checks++; if (bus.dbus_addr !== 64'h1004) begin failures++; $display("FAIL ldw_addr_held got=%h exp=1004", bus.dbus_addr); end
    step();
    clear_in();
    #1;
    checks++; if (wb_valid !== 1'b1) begin failures++; $display("FAIL ldw_wb_valid got=%b exp=1", wb_valid); end
    checks++; if (wb_data !== 64'hFFFF_FFFF_8000_0001) begin failures++; $display("FAIL ldw_wb_data got=%h exp=ffffffff80000001", wb_data); end
    checks++; if (wb_cause !== 5'd0) begin failures++; $display("FAIL ldw_wb_cause got=%h exp=0", wb_cause); end
    checks++; if (wb_rd !== 5'd5) begin failures++; $display("FAIL ldw_wb_rd got=%h exp=5", wb_rd); end
    checks++; if (wb_pc !== 64'h100) begin failures++; $display("FAIL ldw_wb_pc got=%h exp=100", wb_pc); end
    step();
    checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL ldw_wb_pulse got=%b exp=0", wb_valid); end
  endtask

  task automatic test_store_byte();
    int st; bit dn;
    present(0, 1, 2'd0, 0, 64'h2003, 64'hAB, 5'd7, 64'h104);
    #1;
    checks++; if (bus.dbus_wstrb !== 8'h08) begin failures++; $display("FAIL sb_wstrb got=%h exp=08", bus.dbus_wstrb); end
    checks++; if (bus.dbus_wdata !== 64'hAB00_0000) begin failures++; $display("FAIL sb_wdata got=%h exp=ab000000", bus.dbus_wdata); end
    checks++; if (bus.dbus_we !== 1'b1) begin failures++; $display("FAIL sb_we got=%b exp=1", bus.dbus_we); end
    wait_done(1, 1'b1, 1'b0, 64'h0, st, dn);
    checks++; if (st !== 1) begin failures++; $display("FAIL sb_stall_cycles got=%0d exp=1", st); end
    step();
    clear_in();
    #1;
    checks++; if (wb_valid !== 1'b1) begin failures++; $display("FAIL sb_wb_valid got=%b exp=1", wb_valid); end
    checks++; if (wb_rd !== 5'd0) begin failures++; $display("FAIL sb_wb_rd got=%h exp=0", wb_rd); end
    checks++; if (wb_data !== 64'd0) begin failures++; $display("FAIL sb_wb_data got=%h exp=0", wb_data); end
    step();
  endtask

  task automatic test_load_ext();
    int st; bit dn;
    present(1, 0, 2'd0, 1, 64'h4005, 64'h0, 5'd9, 64'h108);
    #1;
    wait_done(1, 1'b1, 1'b0, 64'h0000_8000_0000_0000, st, dn);
    step();
    clear_in();
    #1;
    checks++; if (wb_data !== 64'h80) begin failures++; $display("FAIL lbu_wb_data got=%h exp=80", wb_data); end
    step();
    present(1, 0, 2'd0, 0, 64'h4005, 64'h0, 5'd9, 64'h10C);
    #1;
    wait_done(2, 1'b1, 1'b0, 64'h0000_8000_0000_0000, st, dn);
    step();
    clear_in();
    #1;
    checks++; if (wb_data !== 64'hFFFF_FFFF_FFFF_FF80) begin failures++; $display("FAIL lb_wb_data got=%h exp=ffffffffffffff80", wb_data); end
    step();
  endtask

  task automatic test_misaligned();
    present(1, 0, 2'd1, 0, 64'h1001, 64'h0, 5'd3, 64'h110);
    #1;
    checks++; if (bus.dbus_req !== 1'b0) begin failures++; $display("FAIL lh_mis_req got=%b exp=0", bus.dbus_req); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL lh_mis_stall got=%b exp=0", stall); end
    step();
    present(0, 1, 2'd2, 0, 64'h2002, 64'h0, 5'd4, 64'h114);
    #1;
    checks++; if (wb_valid !== 1'b1) begin failures++; $display("FAIL lh_mis_valid got=%b exp=1", wb_valid); end
    checks++; if (wb_cause !== 5'd4) begin failures++; $display("FAIL lh_mis_cause got=%h exp=4", wb_cause); end
    checks++; if (wb_tval !== 64'h1001) begin failures++; $display("FAIL lh_mis_tval got=%h exp=1001", wb_tval); end
    checks++; if (wb_rd !== 5'd0) begin failures++; $display("FAIL lh_mis_rd got=%h exp=0", wb_rd); end
    step();
    clear_in();
    #1;
    checks++; if (wb_cause !== 5'd6) begin failures++; $display("FAIL sw_mis_cause got=%h exp=6", wb_cause); end
    checks++; if (wb_tval !== 64'h2002) begin failures++; $display("FAIL sw_mis_tval got=%h exp=2002", wb_tval); end
    step();
  endtask

  task automatic test_timeout_err();
    int st; bit dn;
    present(1, 0, 2'd3, 0, 64'h3000, 64'h0, 5'd6, 64'h118);
    #1;
    wait_done(0, 1'b0, 1'b0, 64'h0, st, dn);
    checks++; if (dn !== 1'b1) begin failures++; $display("FAIL tmo_done got=%b exp=1", dn); end
    checks++; if (st !== 4) begin failures++; $display("FAIL tmo_stall_cycles got=%0d exp=4", st); end
    step();
    clear_in();
    #1;
    checks++; if (wb_cause !== 5'd5) begin failures++; $display("FAIL tmo_cause got=%h exp=5", wb_cause); end
    checks++; if (wb_tval !== 64'h3000) begin failures++; $display("FAIL tmo_tval got=%h exp=3000", wb_tval); end
    checks++; if (wb_rd !== 5'd0) begin failures++; $display("FAIL tmo_rd got=%h exp=0", wb_rd); end
    step();
    present(1, 0, 2'd3, 0, 64'h3008, 64'h0, 5'd6, 64'h11C);
    #1;
    wait_done(1, 1'b1, 1'b1, 64'h1122_3344_5566_7788, st, dn);
    step();
    clear_in();
    #1;
    checks++; if (wb_cause !== 5'd0) begin failures++; $display("FAIL ackerr_cause got=%h exp=0", wb_cause); end
    checks++; if (wb_data !== 64'h1122_3344_5566_7788) begin failures++; $display("FAIL ackerr_data got=%h exp=1122334455667788", wb_data); end
    step();
    present(0, 1, 2'd3, 0, 64'h5000, 64'h99, 5'd8, 64'h120);
    #1;
    wait_done(2, 1'b0, 1'b1, 64'h0, st, dn);
    checks++; if (st !== 2) begin failures++; $display("FAIL sderr_stall_cycles got=%0d exp=2", st); end
    step();
    clear_in();
    #1;
    checks++; if (wb_cause !== 5'd7) begin failures++; $display("FAIL sderr_cause got=%h exp=7", wb_cause); end
    checks++; if (wb_tval !== 64'h5000) begin failures++; $display("FAIL sderr_tval got=%h exp=5000", wb_tval); end
    step();
  endtask

  task automatic test_rst_busy();
    present(1, 0, 2'd2, 0, 64'h1004, 64'h0, 5'd5, 64'h124);
    step();
    step();
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL rstb_busy_stall got=%b exp=1", stall); end
    clear_in();
    rst = 1;
    step();
    rst = 0;
    bus.dbus_ack = 1; bus.dbus_rdata = 64'hDEAD;
    #1;
    checks++; if (bus.dbus_req !== 1'b0) begin failures++; $display("FAIL rstb_req got=%b exp=0", bus.dbus_req); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rstb_stall got=%b exp=0", stall); end
    checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL rstb_wb_valid got=%b exp=0", wb_valid); end
    step();
    bus.dbus_ack = 0;
    #1;
    checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL rstb_late_ack got=%b exp=0", wb_valid); end
  endtask

  task automatic test_back_to_back();
    present(0, 0, 2'd0, 0, 64'h11, 64'h0, 5'd1, 64'h200);
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL b2b_stall0 got=%b exp=0", stall); end
    step();
    present(0, 0, 2'd0, 0, 64'h22, 64'h0, 5'd2, 64'h204);
    cause_in = 5'd2; tval_in = 64'h55;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL b2b_stall1 got=%b exp=0", stall); end
    checks++; if (wb_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid0 got=%b exp=1", wb_valid); end
    checks++; if (wb_data !== 64'h11) begin failures++; $display("FAIL b2b_data0 got=%h exp=11", wb_data); end
    checks++; if (wb_rd !== 5'd1) begin failures++; $display("FAIL b2b_rd0 got=%h exp=1", wb_rd); end
    step();
    clear_in();
    #1;
    checks++; if (wb_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid1 got=%b exp=1", wb_valid); end
    checks++; if (wb_cause !== 5'd2) begin failures++; $display("FAIL b2b_cause1 got=%h exp=2", wb_cause); end
    checks++; if (wb_tval !== 64'h55) begin failures++; $display("FAIL b2b_tval1 got=%h exp=55", wb_tval); end
    checks++; if (wb_pc !== 64'h204) begin failures++; $display("FAIL b2b_pc1 got=%h exp=204", wb_pc); end
    step();
    checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL b2b_pulse got=%b exp=0", wb_valid); end
  endtask

  initial begin
    test_reset();
    test_ld_word();
    test_store_byte();
    test_load_ext();
    test_misaligned();
    test_timeout_err();
    test_rst_busy();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
